// File: rtl/mc_controller_if.sv
// mc_controller_if: control bundle between the multi-cycle sequencer and the datapath/memory
interface mc_controller_if #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
);
    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              mem_ready;
    logic              pc_write;
    logic              pc_write_cond;
    logic [1:0]        pc_src;
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              reg_write;
    logic [1:0]        reg_dst;
    logic [1:0]        wb_sel;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUOPW-1:0] alu_op;
    logic              instr_done;
    logic              illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control sequencer with memory ready handshake and illegal-opcode skip
module mc_controller #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input logic            clk,
    input logic            rst_n,
    mc_controller_if.master bus
);
    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_WB_LD    = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BEQ      = 4'd11;
    localparam logic [3:0] S_JMP      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;
    localparam logic [3:0] S_JAL      = 4'd14;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_SLTI = OPW'(2);
    localparam logic [OPW-1:0] OP_LW   = OPW'(3);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);
    localparam logic [OPW-1:0] OP_J    = OPW'(6);
    localparam logic [OPW-1:0] OP_JR   = OPW'(7);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(8);

    localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] ALU_SLT   = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(5);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dispatch;
    logic       w_rdy;

    assign w_rdy = bus.mem_ready;

    // state register; reset parks in RST so every output drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_next;
    end

    // opcode dispatch out of DECODE; undefined opcodes fall back to FETCH
    always_comb begin
        case (bus.opcode)
            OP_R:            w_dispatch = S_EXEC_R;
            OP_ADDI, OP_SLTI: w_dispatch = S_EXEC_I;
            OP_LW, OP_SW:    w_dispatch = S_MEM_ADDR;
            OP_BEQ:          w_dispatch = S_BEQ;
            OP_J:            w_dispatch = S_JMP;
            OP_JR:           w_dispatch = S_JR;
            OP_JAL:          w_dispatch = S_JAL;
            default:         w_dispatch = S_FETCH;
        endcase
    end

    // next-state sequencing; memory states hold until mem_ready
    always_comb begin
        case (r_state)
            S_RST:      w_next = S_FETCH;
            S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_dispatch;
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = w_rdy ? S_WB_LD : S_MEM_RD;
            S_MEM_WR:   w_next = w_rdy ? S_FETCH : S_MEM_WR;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore control decode; only the FETCH writes and sw completion look at mem_ready
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.wb_sel        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = ALU_ADD;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = w_rdy;
                bus.pc_write  = w_rdy;
            end
            S_DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = (w_dispatch == S_FETCH);
                bus.instr_done = (w_dispatch == S_FETCH);
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b01;
                bus.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_WB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
            end
            S_WB_LD: begin
                bus.reg_write  = 1'b1;
                bus.wb_sel     = 2'b01;
                bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                bus.iord       = 1'b1;
                bus.mem_write  = 1'b1;
                bus.instr_done = w_rdy;
            end
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                bus.instr_done    = 1'b1;
            end
            S_JMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b10;
                bus.instr_done = 1'b1;
            end
            S_JR: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b11;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.wb_sel     = 2'b10;
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b10;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
